// File: rtl/aria_rkey_sched.sv
// ARIA round-key scheduler: drives the key-extension datapath, captures W0..W3 and
// streams 13/15/17 round keys in encrypt or decrypt order over a valid/ready port.
module aria_rkey_sched #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [255:0]       key,
  input  logic [1:0]         aria_mode,
  input  logic               dec,
  input  logic               abort,
  output logic [255:0]       kx_key,
  output logic [1:0]         kx_mode,
  output logic               kx_start,
  input  logic               kx_w_valid,
  input  logic [127:0]       kx_w0,
  input  logic [127:0]       kx_w1,
  input  logic [127:0]       kx_w2,
  input  logic [127:0]       kx_w3,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [127:0]       rk_data,
  output logic [CNT_W-1:0]   rk_idx,
  output logic               rk_last,
  output logic               rk_inv,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXP  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam int unsigned WW = 128;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [4*WW-1:0]  w_q, w_nxt, w_src;
  logic             dec_q, dec_nxt;
  logic [255:0]     kx_key_nxt;
  logic [1:0]       kx_mode_nxt;
  logic             kx_start_nxt, err_nxt, busy_nxt;
  logic             rk_valid_nxt, rk_last_nxt, rk_inv_nxt;
  logic [WW-1:0]    rk_data_nxt;
  logic [CNT_W-1:0] rk_idx_nxt;
  logic             load, clear;
  logic [CNT_W-1:0] beat_k, n_keys, ek_sel;
  logic [WW-1:0]    ek_val;

  // Rotation for key group g: R19, R31, L61, L31, L19 (all expressed as right rotates).
  function automatic logic [WW-1:0] rot_grp(input logic [WW-1:0] x, input logic [2:0] g);
    logic [WW-1:0] r;
    case (g)
      3'd0:    r = {x[18:0],  x[127:19]};
      3'd1:    r = {x[30:0],  x[127:31]};
      3'd2:    r = {x[66:0],  x[127:67]};
      3'd3:    r = {x[96:0],  x[127:97]};
      default: r = {x[108:0], x[127:109]};
    endcase
    return r;
  endfunction

  function automatic logic [WW-1:0] ek_f(input logic [4:0] i, input logic [WW-1:0] w0,
                                         input logic [WW-1:0] w1, input logic [WW-1:0] w2,
                                         input logic [WW-1:0] w3);
    logic [4:0]    i0;
    logic [WW-1:0] r;
    i0 = i - 5'd1;
    case (i0[1:0])
      2'd0:    r = w0 ^ rot_grp(w1, i0[4:2]);
      2'd1:    r = w1 ^ rot_grp(w2, i0[4:2]);
      2'd2:    r = w2 ^ rot_grp(w3, i0[4:2]);
      default: r = rot_grp(w0, i0[4:2]) ^ w3;
    endcase
    return r;
  endfunction

  // The first key is built straight from the extension outputs on the capture cycle.
  assign w_src  = (state == S_EXP) ? {kx_w3, kx_w2, kx_w1, kx_w0} : w_q;
  assign n_keys = (kx_mode == 2'b00) ? CNT_W'(13) :
                  (kx_mode == 2'b01) ? CNT_W'(15) : CNT_W'(17);
  assign ek_sel = dec_q ? CNT_W'(n_keys + 1'b1 - beat_k) : beat_k;
  assign ek_val = ek_f(5'(ek_sel), w_src[WW-1:0], w_src[2*WW-1:WW],
                       w_src[3*WW-1:2*WW], w_src[4*WW-1:3*WW]);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    w_nxt        = w_q;
    dec_nxt      = dec_q;
    kx_key_nxt   = kx_key;
    kx_mode_nxt  = kx_mode;
    kx_start_nxt = 1'b0;
    err_nxt      = 1'b0;
    load         = 1'b0;
    clear        = 1'b0;
    beat_k       = CNT_W'(rk_idx + 1'b1);

    case (state)
      S_IDLE: begin
        if (start) begin
          if (aria_mode == 2'b11) begin
            err_nxt = 1'b1;
          end else begin
            kx_key_nxt   = key;
            kx_mode_nxt  = aria_mode;
            dec_nxt      = dec;
            wait_cnt_nxt = '0;
            kx_start_nxt = 1'b1;
            state_nxt    = S_EXP;
          end
        end
      end
      S_EXP: begin
        // W is only trusted from the cycle after the kx_start pulse.
        if ((wait_cnt != '0) && kx_w_valid) begin
          w_nxt     = {kx_w3, kx_w2, kx_w1, kx_w0};
          beat_k    = CNT_W'(1);
          load      = 1'b1;
          state_nxt = S_OUT;
        end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          wait_cnt_nxt = CNT_W'(wait_cnt + 1'b1);
        end
      end
      S_OUT: begin
        if (rk_valid && rk_ready) begin
          if (rk_last) begin
            clear     = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (abort) begin
      state_nxt    = S_IDLE;
      wait_cnt_nxt = '0;
      kx_start_nxt = 1'b0;
      err_nxt      = 1'b0;
      load         = 1'b0;
      clear        = 1'b1;
      kx_key_nxt   = kx_key;
      kx_mode_nxt  = kx_mode;
      dec_nxt      = dec_q;
    end

    rk_valid_nxt = rk_valid;
    rk_data_nxt  = rk_data;
    rk_idx_nxt   = rk_idx;
    rk_last_nxt  = rk_last;
    rk_inv_nxt   = rk_inv;
    if (load) begin
      rk_valid_nxt = 1'b1;
      rk_data_nxt  = ek_val;
      rk_idx_nxt   = beat_k;
      rk_last_nxt  = (beat_k == n_keys);
      rk_inv_nxt   = dec_q && (beat_k != CNT_W'(1)) && (beat_k != n_keys);
    end else if (clear) begin
      rk_valid_nxt = 1'b0;
      rk_data_nxt  = '0;
      rk_idx_nxt   = '0;
      rk_last_nxt  = 1'b0;
      rk_inv_nxt   = 1'b0;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      w_q      <= '0;
      dec_q    <= 1'b0;
      kx_key   <= '0;
      kx_mode  <= '0;
      kx_start <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
      rk_inv   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      w_q      <= w_nxt;
      dec_q    <= dec_nxt;
      kx_key   <= kx_key_nxt;
      kx_mode  <= kx_mode_nxt;
      kx_start <= kx_start_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      rk_valid <= rk_valid_nxt;
      rk_data  <= rk_data_nxt;
      rk_idx   <= rk_idx_nxt;
      rk_last  <= rk_last_nxt;
      rk_inv   <= rk_inv_nxt;
    end
  end

endmodule

// File: tb/tb_aria_rkey_sched.sv
// Self-checking bench for aria_rkey_sched: table of full key streams scored against a
// reference model through an expected-beat queue, plus hand-written control sequences.
module tb_aria_rkey_sched;

  localparam int unsigned WAIT_MAX = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key;
  logic [1:0]   aria_mode;
  logic         dec;
  logic         abort;
  logic [255:0] kx_key;
  logic [1:0]   kx_mode;
  logic         kx_start;
  logic         kx_w_valid;
  logic [127:0] kx_w0, kx_w1, kx_w2, kx_w3;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [4:0]   rk_idx;
  logic         rk_last;
  logic         rk_inv;
  logic         busy;
  logic         err;

  aria_rkey_sched #(.WAIT_MAX(WAIT_MAX), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .aria_mode(aria_mode), .dec(dec),
    .abort(abort), .kx_key(kx_key), .kx_mode(kx_mode), .kx_start(kx_start),
    .kx_w_valid(kx_w_valid), .kx_w0(kx_w0), .kx_w1(kx_w1), .kx_w2(kx_w2), .kx_w3(kx_w3),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx),
    .rk_last(rk_last), .rk_inv(rk_inv), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   idx;
    logic         last;
    logic         inv;
  } beat_t;

  typedef struct {
    logic [1:0]   mode;
    logic         dec;
    int           rdy;    // 0 always ready, 1 toggle, 2 random
    int           wdly;   // extra cycles before kx_w_valid rises
    logic [127:0] w0, w1, w2, w3;
    int           exp_n;
  } run_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    ready_mode = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 256'(act), 256'(exp));
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    chk(name, 256'(act), 256'(exp));
  endtask

  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    return (x << n) | (x >> (128 - n));
  endfunction

  function automatic logic [127:0] rotr(input logic [127:0] x, input int n);
    return (x >> n) | (x << (128 - n));
  endfunction

  // Reference: ek_i = a ^ rot(b) with (a,b) = (W0,W1),(W1,W2),(W2,W3),(W3,W0) per group.
  function automatic logic [127:0] m_ek(input int i, input logic [127:0] w0, input logic [127:0] w1,
                                        input logic [127:0] w2, input logic [127:0] w3);
    logic [127:0] a, b, rb;
    int g, p;
    g = (i - 1) / 4;
    p = (i - 1) % 4;
    case (p)
      0: begin a = w0; b = w1; end
      1: begin a = w1; b = w2; end
      2: begin a = w2; b = w3; end
      default: begin a = w3; b = w0; end
    endcase
    case (g)
      0: rb = rotr(b, 19);
      1: rb = rotr(b, 31);
      2: rb = rotl(b, 61);
      3: rb = rotl(b, 31);
      default: rb = rotl(b, 19);
    endcase
    return a ^ rb;
  endfunction

  task automatic push_stream(input logic [1:0] mode, input logic d, input logic [127:0] w0,
                             input logic [127:0] w1, input logic [127:0] w2,
                             input logic [127:0] w3, input int upto);
    int    n;
    beat_t b;
    n = (mode == 2'b00) ? 13 : (mode == 2'b01) ? 15 : 17;
    for (int k = 1; k <= upto; k++) begin
      b.data = m_ek(d ? (n + 1 - k) : k, w0, w1, w2, w3);
      b.idx  = 5'(k);
      b.last = (k == n);
      b.inv  = d && (k != 1) && (k != n);
      exp_q.push_back(b);
    end
  endtask

  // Consumer ready pattern, updated just after each rising edge.
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rk_ready = 1'b1;
        1:       rk_ready = ~rk_ready;
        default: rk_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Every valid cycle is checked against the queue head; a handshake retires it.
  always @(negedge clk) begin
    if (rst_n && rk_valid) begin
      if (exp_q.size() == 0) begin
        chk1("unexpected_rk_valid", rk_valid, 1'b0);
      end else begin
        chk($sformatf("beat%0d", exp_q[0].idx), 256'({rk_data, rk_idx, rk_last, rk_inv}),
            256'({exp_q[0].data, exp_q[0].idx, exp_q[0].last, exp_q[0].inv}));
        if (rk_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_stream_end(input string name, output int span);
    bit seen, done;
    seen = 0; done = 0; span = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (rk_valid) seen = 1;
      if (seen) span++;
      if (rk_valid && rk_ready && rk_last) done = 1;
    end
    chk1({name, "_done"}, done, 1'b1);
  endtask

  task automatic run_one(input run_t r, input int ri);
    logic [255:0] k;
    int span;
    k = {r.w0 ^ 128'(ri + 1), ~r.w3};
    ready_mode = r.rdy;
    kx_w0 = r.w0; kx_w1 = r.w1; kx_w2 = r.w2; kx_w3 = r.w3;
    kx_w_valid = (r.wdly == 0);
    push_stream(r.mode, r.dec, r.w0, r.w1, r.w2, r.w3, r.exp_n);
    start = 1'b1; aria_mode = r.mode; dec = r.dec; key = k;
    @(posedge clk); #1;
    chk1($sformatf("run%0d_kx_start", ri), kx_start, 1'b1);
    chk1($sformatf("run%0d_busy", ri), busy, 1'b1);
    chk($sformatf("run%0d_kx_key", ri), kx_key, k);
    chk($sformatf("run%0d_kx_mode", ri), 256'(kx_mode), 256'(r.mode));
    // A start and new config while busy must be ignored.
    key = ~k; aria_mode = 2'b11; dec = ~r.dec;
    @(posedge clk); #1;
    start = 1'b0;
    chk1($sformatf("run%0d_no_restart", ri), kx_start, 1'b0);
    if (r.wdly > 0) begin
      repeat (r.wdly) @(posedge clk);
      #1;
      kx_w_valid = 1'b1;
    end
    wait_stream_end($sformatf("run%0d", ri), span);
    if (r.rdy == 0) chk_int($sformatf("run%0d_zero_bubble", ri), span, r.exp_n);
    @(posedge clk); #1;
    kx_w_valid = 1'b0;
    chk1($sformatf("run%0d_idle", ri), busy, 1'b0);
    chk1($sformatf("run%0d_valid_low", ri), rk_valid, 1'b0);
    chk_int($sformatf("run%0d_queue_empty", ri), exp_q.size(), 0);
    chk($sformatf("run%0d_kx_key_held", ri), kx_key, k);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    run_t runs[6];
    int   c;
    bit   found;
    int   span;

    runs[0] = '{2'b00, 1'b0, 0, 0, 128'h000102030405060708090a0b0c0d0e0f,
                128'h0123456789abcdeffedcba9876543210, 128'hdeadbeefcafef00d1122334455667788,
                128'h8899aabbccddeeff0011223344556677, 13};
    runs[1] = '{2'b10, 1'b1, 0, 2, 128'h5a5a5a5aa5a5a5a5f0f0f0f00f0f0f0f,
                128'h13579bdf2468ace0fedcba9876543210, 128'h00000000000000000000000000000001,
                128'h80000000000000000000000000000000, 17};
    runs[2] = '{2'b01, 1'b0, 1, 1, 128'hfeedfacecafebabe0123456789abcdef,
                128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h1111111122222222333333334444444,
                128'habcdef0123456789abcdef0123456789, 15};
    runs[3] = '{2'b01, 1'b1, 2, 3, 128'h7777777788888888999999990000aaaa,
                128'h0000ffff0000ffff0000ffff0000ffff, 128'h3141592653589793238462643383279,
                128'h2718281828459045235360287471352, 15};
    runs[4] = '{2'b00, 1'b1, 1, 0, 128'h1, 128'h0, 128'h0, 128'h0, 13};
    runs[5] = '{2'b10, 1'b0, 2, 5, 128'hc0ffee00c0ffee00c0ffee00c0ffee00,
                128'h0badf00d0badf00d0badf00d0badf00d, 128'h600dcafe600dcafe600dcafe600dcafe,
                128'h123456789abcdef00fedcba987654321, 17};

    rst_n = 1'b0; start = 1'b0; key = '0; aria_mode = 2'b00; dec = 1'b0; abort = 1'b0;
    kx_w_valid = 1'b0; kx_w0 = '0; kx_w1 = '0; kx_w2 = '0; kx_w3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_rk_valid", rk_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_kx_start", kx_start, 1'b0);
    chk("rst_kx_key", kx_key, 256'(0));
    chk("rst_rk_fields", 256'({rk_data, rk_idx, rk_last, rk_inv, kx_mode}), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_one(runs[i], i);

    // Illegal mode: one-cycle err, no kx_start, stays idle.
    ready_mode = 0;
    start = 1'b1; aria_mode = 2'b11; key = {8{32'h11111111}};
    @(posedge clk); #1;
    start = 1'b0;
    chk1("ill_err", err, 1'b1);
    chk1("ill_busy", busy, 1'b0);
    chk1("ill_kx_start", kx_start, 1'b0);
    chk("ill_kx_mode_held", 256'(kx_mode), 256'(runs[5].mode));
    @(posedge clk); #1;
    chk1("ill_err_pulse", err, 1'b0);
    chk1("ill_kx_start2", kx_start, 1'b0);
    chk1("ill_busy2", busy, 1'b0);

    // Extension never answers: err exactly WAIT_MAX cycles after kx_start.
    kx_w_valid = 1'b0; aria_mode = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("to_kx_start", kx_start, 1'b1);
    c = 1;
    while (c <= 40) begin
      @(posedge clk); #1;
      if (err) break;
      c++;
    end
    chk_int("to_err_latency", c, WAIT_MAX);
    chk1("to_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk1("to_err_pulse", err, 1'b0);

    // abort and start in the same idle cycle: abort wins.
    abort = 1'b1; start = 1'b1; aria_mode = 2'b01;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk1("abst_busy", busy, 1'b0);
    chk1("abst_kx_start", kx_start, 1'b0);

    // Abort at idx 5, restart next cycle, fresh stream from idx 1.
    ready_mode = 0;
    kx_w0 = runs[5].w0; kx_w1 = runs[5].w1; kx_w2 = runs[5].w2; kx_w3 = runs[5].w3;
    kx_w_valid = 1'b1;
    push_stream(2'b10, 1'b0, runs[5].w0, runs[5].w1, runs[5].w2, runs[5].w3, 5);
    start = 1'b1; aria_mode = 2'b10; dec = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (rk_valid && rk_idx == 5'd5) found = 1;
    end
    chk1("ab_reach_idx5", found, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk1("ab_valid_low", rk_valid, 1'b0);
    chk1("ab_busy_low", busy, 1'b0);
    chk1("ab_no_err", err, 1'b0);
    chk_int("ab_queue_drained", exp_q.size(), 0);
    kx_w0 = runs[0].w0; kx_w1 = runs[0].w1; kx_w2 = runs[0].w2; kx_w3 = runs[0].w3;
    push_stream(2'b00, 1'b1, runs[0].w0, runs[0].w1, runs[0].w2, runs[0].w3, 13);
    start = 1'b1; aria_mode = 2'b00; dec = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("ab_restart_kx_start", kx_start, 1'b1);
    chk1("ab_restart_valid_low", rk_valid, 1'b0);
    wait_stream_end("ab_restart", span);
    chk_int("ab_restart_span", span, 13);
    @(posedge clk); #1;
    chk_int("ab_restart_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-stream clears everything at once.
    push_stream(2'b01, 1'b0, runs[0].w0, runs[0].w1, runs[0].w2, runs[0].w3, 15);
    start = 1'b1; aria_mode = 2'b01; dec = 1'b0; key = {4{64'h0123456789abcdef}};
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (rk_valid && rk_idx == 5'd3) found = 1;
    end
    chk1("rst_mid_reach_idx3", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk1("rst_mid_valid", rk_valid, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_kx_key", kx_key, 256'(0));
    chk("rst_mid_rk", 256'({rk_data, rk_idx}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    kx_w_valid = 1'b0;
    @(posedge clk); #1;
    chk1("rst_mid_idle_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
